// File: rtl/demux_pkg.sv
// demux_pkg: shared constants for the registered 1-to-4 demultiplexer.
// Channel count, default data width and select encodings live here so the
// top level and any checker agree on one definition.
package demux_pkg;

   localparam int PKG_N_CH   = 4;
   localparam int PKG_DATA_W = 8;

   typedef logic [1:0] sel_t;

   localparam sel_t CH0_SEL = 2'b00;
   localparam sel_t CH1_SEL = 2'b01;
   localparam sel_t CH2_SEL = 2'b10;
   localparam sel_t CH3_SEL = 2'b11;

   // One-hot decode of a channel select, using the shared encodings.
   function automatic logic [PKG_N_CH-1:0] sel_decode(input sel_t sel);
      logic [PKG_N_CH-1:0] oh;
      oh = '0;
      case (sel)
         CH0_SEL: oh[0] = 1'b1;
         CH1_SEL: oh[1] = 1'b1;
         CH2_SEL: oh[2] = 1'b1;
         CH3_SEL: oh[3] = 1'b1;
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for a single demux output channel.
// A load always wins over a drain, so a same-cycle drain and load keeps the
// slot full and replaces its word with no bubble. The word is kept after a
// drain; only reset clears it.
module demux_slot #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              drain,
   input  logic [DATA_W-1:0] load_data,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   // Occupancy and payload register; load has priority over drain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_1x4_reg.sv
// demux_1x4_reg: registered 1-to-4 demultiplexer with valid/ready handshakes.
// Optional feature: define DEMUX_DELIV_CNT_EN to add the deliv_cnt output,
// four 8-bit wrapping per-channel delivery counters.
//
// Handshake rules (both sides): a word moves when valid && ready are high in
// the same cycle. valid never depends on ready. The input side accepts when
// the selected slot is empty or is being drained in the same cycle, so
// in_ready is a pure function of in_select, out_valid and out_ready.
module demux_1x4_reg
   import demux_pkg::*;
#(
   parameter int DATA_W = PKG_DATA_W,
   parameter int N_CH   = PKG_N_CH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_select,
   output logic [3:0]        out_valid,
   input  logic [3:0]        out_ready,
   output logic [DATA_W-1:0] out_data0,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic [DATA_W-1:0] out_data3
`ifdef DEMUX_DELIV_CNT_EN
   ,
   output logic [31:0]       deliv_cnt
`endif
);

   logic [PKG_N_CH-1:0] sel_oh;
   logic                accept;
   logic [PKG_N_CH-1:0] load;
   logic [PKG_N_CH-1:0] drain;
   logic [DATA_W-1:0]   slot_data [PKG_N_CH];

   // Select decode, accept and per-channel load/drain strobes.
   always_comb begin
      sel_oh   = sel_decode(sel_t'(in_select));
      in_ready = ~out_valid[in_select] | out_ready[in_select];
      accept   = in_valid & in_ready;
      load     = sel_oh & {PKG_N_CH{accept}};
      drain    = out_valid & out_ready;
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_slot
      demux_slot #(
         .DATA_W (DATA_W)
      ) u_slot (
         .clk       (clk),
         .reset_n   (reset_n),
         .load      (load[i]),
         .drain     (drain[i]),
         .load_data (in_data),
         .valid     (out_valid[i]),
         .data      (slot_data[i])
      );
   end

   assign out_data0 = slot_data[0];
   assign out_data1 = slot_data[1];
   assign out_data2 = slot_data[2];
   assign out_data3 = slot_data[3];

`ifdef DEMUX_DELIV_CNT_EN
   logic [7:0] cnt [PKG_N_CH];

   for (genvar i = 0; i < N_CH; i++) begin : g_cnt
      // Count drains on channel i; the 8-bit counter wraps naturally.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt[i] <= '0;
         end else if (drain[i]) begin
            cnt[i] <= cnt[i] + 8'd1;
         end
      end
   end

   assign deliv_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_demux_1x4_reg.sv
// tb_demux_1x4_reg: self-checking bench for demux_1x4_reg.
// Inputs change 1 time unit after the rising edge; a negedge monitor keeps a
// per-channel expected queue plus last-loaded values and checks the DUT.
module tb_demux_1x4_reg;

   localparam int W = 8;

   logic         clk;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [1:0]   in_select;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX_DELIV_CNT_EN
   logic [31:0]  deliv_cnt;
   logic [7:0]   cnt_model [4];
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_q [4][$];
   logic [W-1:0] last_val [4];

   demux_1x4_reg #(
      .DATA_W (W),
      .N_CH   (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_select (in_select),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3)
`ifdef DEMUX_DELIV_CNT_EN
      ,
      .deliv_cnt (deliv_cnt)
`endif
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [W-1:0] get_data(input int ch);
      case (ch)
         0: return out_data0;
         1: return out_data1;
         2: return out_data2;
         default: return out_data3;
      endcase
   endfunction

   task automatic clear_model();
      for (int c = 0; c < 4; c++) begin
         exp_q[c].delete();
         last_val[c] = '0;
`ifdef DEMUX_DELIV_CNT_EN
         cnt_model[c] = '0;
`endif
      end
   endtask

   // Driver tasks
   task automatic set_in(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [3:0] r);
      in_valid  = v;
      in_select = s;
      in_data   = d;
      out_ready = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse between edges; checks the immediate effect.
   task automatic reset_pulse();
      #1;
      reset_n = 1'b0;
      #1;
      check("rst_valid", {28'd0, out_valid}, 32'h0);
      check("rst_d0", {24'd0, out_data0}, 32'h0);
      check("rst_d1", {24'd0, out_data1}, 32'h0);
      check("rst_d2", {24'd0, out_data2}, 32'h0);
      check("rst_d3", {24'd0, out_data3}, 32'h0);
      check("rst_ready", {31'd0, in_ready}, 32'h1);
`ifdef DEMUX_DELIV_CNT_EN
      check("rst_cnt", deliv_cnt, 32'h0);
`endif
      clear_model();
      #1;
      reset_n = 1'b1;
      tick();
   endtask

   // Scoreboard monitor: checks state, then consumes drains and records accepts.
   always @(negedge clk) begin
      if (reset_n) begin
         logic exp_rdy;
         for (int c = 0; c < 4; c++) begin
            check($sformatf("valid%0d", c), {31'd0, out_valid[c]},
                  {31'd0, (exp_q[c].size() != 0)});
            check($sformatf("hold%0d", c), {24'd0, get_data(c)}, {24'd0, last_val[c]});
         end
`ifdef DEMUX_DELIV_CNT_EN
         check("cnt", deliv_cnt, {cnt_model[3], cnt_model[2], cnt_model[1], cnt_model[0]});
`endif
         exp_rdy = (exp_q[in_select].size() == 0) || out_ready[in_select];
         check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         for (int c = 0; c < 4; c++) begin
            if (out_valid[c] && out_ready[c]) begin
               if (exp_q[c].size() == 0) begin
                  check($sformatf("spurious%0d", c), 32'h1, 32'h0);
               end else begin
                  check($sformatf("drain%0d", c), {24'd0, get_data(c)},
                        {24'd0, exp_q[c].pop_front()});
               end
`ifdef DEMUX_DELIV_CNT_EN
               cnt_model[c] = cnt_model[c] + 8'd1;
`endif
            end
         end
         if (in_valid && in_ready) begin
            exp_q[in_select].push_back(in_data);
            last_val[in_select] = in_data;
         end
      end
   end

   // Stimulus
   initial begin
      reset_n = 1'b0;
      set_in(1'b0, 2'b00, '0, 4'b0000);
      clear_model();
      #3;
      check("init_valid", {28'd0, out_valid}, 32'h0);
      check("init_ready", {31'd0, in_ready}, 32'h1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();

      // Basic routing to channel 2
      set_in(1'b1, 2'b10, 8'hA5, 4'b0000);
      #1;
      check("route_ready", {31'd0, in_ready}, 32'h1);
      tick();
      check("route_valid", {28'd0, out_valid}, 32'h4);
      check("route_d2", {24'd0, out_data2}, 32'hA5);
      check("route_d0", {24'd0, out_data0}, 32'h0);
      set_in(1'b0, 2'b00, 8'h00, 4'b0100);
      tick();
      check("route_drained", {28'd0, out_valid}, 32'h0);

      // Backpressure on channel 1
      set_in(1'b1, 2'b01, 8'h77, 4'b0000);
      tick();
      set_in(1'b1, 2'b01, 8'h3C, 4'b0000);
      #1;
      check("bp_ready_low", {31'd0, in_ready}, 32'h0);
      tick();
      check("bp_d1_held", {24'd0, out_data1}, 32'h77);
      set_in(1'b1, 2'b01, 8'h3C, 4'b0010);
      #1;
      check("bp_ready_high", {31'd0, in_ready}, 32'h1);
      tick();
      check("bp_d1_new", {24'd0, out_data1}, 32'h3C);
      check("bp_valid", {28'd0, out_valid}, 32'h2);
      set_in(1'b0, 2'b00, 8'h00, 4'b0010);
      tick();

      // Simultaneous drain and accept on channel 3
      set_in(1'b1, 2'b11, 8'h11, 4'b0000);
      tick();
      set_in(1'b1, 2'b11, 8'h22, 4'b1000);
      tick();
      check("sim_valid3", {31'd0, out_valid[3]}, 32'h1);
      check("sim_d3", {24'd0, out_data3}, 32'h22);
      set_in(1'b0, 2'b00, 8'h00, 4'b1000);
      tick();

      // Independent channels
      for (int c = 0; c < 4; c++) begin
         set_in(1'b1, 2'(c), 8'(c + 1), 4'b0000);
         tick();
      end
      set_in(1'b0, 2'b00, 8'h00, 4'b0100);
      tick();
      check("ind_valid", {28'd0, out_valid}, 32'hB);
      check("ind_d0", {24'd0, out_data0}, 32'h01);
      check("ind_d1", {24'd0, out_data1}, 32'h02);
      check("ind_d2_last", {24'd0, out_data2}, 32'h03);
      check("ind_d3", {24'd0, out_data3}, 32'h04);
      set_in(1'b0, 2'b01, 8'h00, 4'b0000);

      // Reset mid-operation, then first load after release
      reset_pulse();
      set_in(1'b1, 2'b00, 8'h5A, 4'b0000);
      tick();
      check("post_rst_valid", {28'd0, out_valid}, 32'h1);
      check("post_rst_d0", {24'd0, out_data0}, 32'h5A);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
         tick();
      end

`ifdef DEMUX_DELIV_CNT_EN
      // 257 drains on channel 0 wrap its counter to 1
      set_in(1'b0, 2'b00, 8'h00, 4'b0000);
      reset_pulse();
      for (int i = 0; i < 258; i++) begin
         set_in(1'b1, 2'b00, 8'(i), 4'b0001);
         tick();
      end
      set_in(1'b0, 2'b00, 8'h00, 4'b0000);
      tick();
      check("cnt_257", deliv_cnt, 32'h0000_0001);
`endif

      // Drain everything left
      set_in(1'b0, 2'b00, 8'h00, 4'b1111);
      tick();
      tick();
      check("final_valid", {28'd0, out_valid}, 32'h0);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("final_q%0d", c), exp_q[c].size(), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
